serial_sub: RTL

//  Multi-cycle ripple-borrow subtractor; the inverse operation of the team's ripple-carry adder.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_digit.sv | 24 ++
 rtl/serial_sub.sv | 94 +++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial ripple-borrow subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must be able to hold NDIG itself, hence the +1.
  function automatic int cnt_w(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/serial_sub_digit.sv
// One DIGIT-wide ripple-borrow slice: d = x - y - bi, bo = (x < y + bi).
module sub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] br;

  assign br[0] = bi;

  // Full-subtractor chain, the borrow counterpart of the adder's carry chain.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bo = br[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w(WIDTH, DIGIT);

  if (WIDTH % DIGIT != 0) begin : g_width_chk
    $error("serial_sub: WIDTH must be an integer multiple of DIGIT");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               brw;
  logic [DIGIT-1:0]   d_slice;
  logic               bo_slice;
  logic               accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == BUSY) && (cnt == CNT_W'(NDIG - 1));

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (brw),
    .d  (d_slice),
    .bo (bo_slice)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt  <= '0;
        brw  <= bin;
        diff <= '0;
      end else if (state == BUSY) begin
        brw <= bo_slice;
        cnt <= cnt + CNT_W'(1);
        for (int k = 0; k < NDIG; k++) begin
          if (int'(cnt) == k) diff[k*DIGIT +: DIGIT] <= d_slice;
        end
        if (last) bout <= bo_slice;
      end
    end
  end

  // Operand shifters: pure data, consumed one digit per BUSY clock.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
    end
  end

endmodule
